pokey_poly_counters: RTL
========================

Name: pokey_poly_counters

Overview:
Source side of the POKEY noise path. Generates the 4-bit, 5-bit, 9-bit and 17-bit polynomial-counter bit streams that feed the per-channel noise filters as noise_4, noise_5 and noise_large. Also supplies the 8-bit RANDOM register value to the CPU read mux. All counters advance once per machine-clock enable (ce, nominally 1.79 MHz).

Parameters:
RANDOM_INVERT, 1, when 1, random_out is the bitwise inverse of the selected poly bits; when 0, it is the bits as-is.

Ports:
clk  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
ce  input  1  machine-cycle enable; counters step only when ce=1
init  input  1  SKCTL[1:0]==00 init mode; holds all counters in reset state
poly17_9  input  1  AUDCTL bit 7; 1 selects the 9-bit poly for noise_large/random_out, 0 selects the 17-bit poly
noise_4  output  1  poly4 output bit
noise_5  output  1  poly5 output bit
noise_large  output  1  selected 9- or 17-bit poly output bit
random_out  output  8  RANDOM register value

Behaviour:
- Four independent registers: p4[3:0], p5[4:0], p9[8:0], p17[16:0].
- Each register is a Fibonacci right-shift LFSR with XNOR feedback.
- On each step:
  - The register shifts right by one.
  - The new MSB is the XNOR of its taps.
  - p4: new = ~(p4[0]^p4[1])
  - p5: new = ~(p5[0]^p5[2])
  - p9: new = ~(p9[0]^p9[4])
  - p17: new = ~(p17[0]^p17[3])
- Maximal-length periods: p4 = 15, p5 = 31, p9 = 511, p17 = 131071.
- The all-ones state is the lockup state. It is unreachable from reset.
- Outputs are taken straight from register bits, with no extra latency:
  - noise_4 = p4[0]
  - noise_5 = p5[0]
  - noise_large = poly17_9 ? p9[0] : p17[0]
  - random_out = poly17_9 ? p9[8:1] : p17[16:9], inverted when RANDOM_INVERT=1
- Priority, per clk edge, highest first:
  - reset=1: all registers go to 0, regardless of ce or init.
  - init=1 (reset=0): all registers go to 0, regardless of ce. They stay at 0 while init is held.
  - ce=1: all four registers step once.
  - Otherwise: all registers hold.
- Reset/init values:
  - noise_4, noise_5 and noise_large = 0.
  - random_out = 8'hFF when RANDOM_INVERT=1, else 8'h00.
- Releasing init: the first ce after init falls produces the first step. The sequence restarts from the all-zero state, so noise streams are repeatable.
- p9 and p17 both run continuously, whichever is selected.
  - Toggling poly17_9 switches noise_large and random_out combinationally in the same cycle.
  - Neither register is disturbed or reset by the switch.
- reset or init asserted mid-sequence: takes effect on that clock edge. No partial step occurs.
- ce may be asserted on consecutive clocks; every such cycle is one step.
- No multi-cycle state exists, so ce=0 gaps have no effect other than holding.

Test Plan:
- Reset: hold reset 2 clocks with ce=1 and init=0 -> all noise outputs 0 and random_out=8'hFF. Then three ce steps -> p4 states 1000, 1100, 1110; noise_4 stays 0 over those steps.
- Period: run ce continuously from reset.
  - p4 returns to 0000 after exactly 15 steps.
  - p5 returns to 00000 after 31 steps.
  - With poly17_9=1, p9 returns to all-zero after 511 steps.
  - With poly17_9=0, p17 returns to all-zero after 131071 steps.
  - None of the registers is ever all-ones.
- ce gating: insert ce=0 gaps of random length between steps -> the noise sequences are identical to the continuous-ce run, compared per step.
- init: after 100 steps, assert init for 3 clocks with ce=1 -> all registers 0 and random_out=8'hFF. Release init -> the sequence matches a fresh post-reset run step for step.
- Poly select: after 600 steps, toggle poly17_9 1->0->1 on consecutive clocks with ce=0.
  - noise_large and random_out follow p17/p9 immediately.
  - Compared against a reference model with no select change, p9 and p17 states are unchanged.
- Priority: assert reset and init together with ce=1 -> zeros. Then deassert reset while holding init and ce -> registers remain 0.

Source files
------------

// File: rtl/pokey_poly_counters.sv
// POKEY polynomial-counter noise sources: 4/5/9/17-bit XNOR Fibonacci LFSRs
// feeding the channel noise filters and the RANDOM read register.
module pokey_poly_counters #(
   parameter bit RANDOM_INVERT = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic       init,
   input  logic       poly17_9,
   output logic       noise_4,
   output logic       noise_5,
   output logic       noise_large,
   output logic [7:0] random_out
);

   logic [3:0]  p4_q,  p4_d;
   logic [4:0]  p5_q,  p5_d;
   logic [8:0]  p9_q,  p9_d;
   logic [16:0] p17_q, p17_d;
   logic [7:0]  random_sel;

   // XNOR feedback makes all-zero the legal start state and all-ones the lockup
   always_comb begin
      p4_d  = p4_q;
      p5_d  = p5_q;
      p9_d  = p9_q;
      p17_d = p17_q;
      if (init) begin
         p4_d  = '0;
         p5_d  = '0;
         p9_d  = '0;
         p17_d = '0;
      end else if (ce) begin
         p4_d  = {~(p4_q[0]  ^ p4_q[1]),  p4_q[3:1]};
         p5_d  = {~(p5_q[0]  ^ p5_q[2]),  p5_q[4:1]};
         p9_d  = {~(p9_q[0]  ^ p9_q[4]),  p9_q[8:1]};
         p17_d = {~(p17_q[0] ^ p17_q[3]), p17_q[16:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p4_q  <= '0;
         p5_q  <= '0;
         p9_q  <= '0;
         p17_q <= '0;
      end else begin
         p4_q  <= p4_d;
         p5_q  <= p5_d;
         p9_q  <= p9_d;
         p17_q <= p17_d;
      end
   end

   always_comb begin
      random_sel  = poly17_9 ? p9_q[8:1] : p17_q[16:9];
      noise_4     = p4_q[0];
      noise_5     = p5_q[0];
      noise_large = poly17_9 ? p9_q[0] : p17_q[0];
      random_out  = RANDOM_INVERT ? ~random_sel : random_sel;
   end

endmodule
